serial_responder: RTL and testbench

Responder (slave) end of the team's 3-wire serial link: clock in, data in, data out. The initiator drives the serial clock; this block samples it in the main clock domain. It deserialises incoming words to parallel and serialises an outgoing word back to the initiator. It sits on the IC/peripheral side of the link, or in FPGA-to-FPGA loopback benches, opposite the existing serial initiator.

---
 rtl/serial_responder.sv | 180 ++++++++++++++++++
 tb/tb_serial_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_responder.sv
// serial_responder: responder end of the 3-wire serial link.
// Samples the initiator's serial clock and data in the in_clk domain,
// deserialises received words onto out_parallel and serialises the word
// captured from in_parallel back out on out_serial.
//
// Optional feature: define SERIAL_RESP_TIMEOUT_EN to compile in the idle
// counter that aborts a partial word after TIMEOUT_CYCLES cycles of idle
// serial clock (pulsing out_frame_error). Without it out_frame_error is tied
// low and word alignment is only recovered by in_rst.
//
// Handshake: out_next_word is a 1-cycle pulse after in_parallel has been
// captured, so the producer may present the following word. out_word_valid
// is a 1-cycle pulse in the cycle out_parallel carries a new word. There is
// no back-pressure on either side.
module serial_responder #(
  parameter int   BITS                 = 8,
  parameter logic LOWBIT_FIRST         = 1'b1,
  parameter logic SERIAL_CLK_INACTIVE  = 1'b1,
  parameter logic SERIAL_DATA_INACTIVE = 1'b1,
  parameter int   SYNC_STAGES          = 2,
  parameter int   TIMEOUT_CYCLES       = 1024
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial_clk,
  input  logic            in_serial,
  output logic            out_serial,
  input  logic [BITS-1:0] in_parallel,
  output logic            out_next_word,
  output logic [BITS-1:0] out_parallel,
  output logic            out_word_valid,
  output logic            out_busy,
  output logic            out_frame_error
);

  localparam int CW = $clog2(BITS) + 1;
  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BITS - 1);
  localparam logic [IW-1:0] FIRST = LOWBIT_FIRST ? IW'(0) : IW'(BITS - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          bit_ctr_q;
  logic [BITS-1:0]        tx_buf_q;
  logic [BITS-1:0]        rx_buf_q;
  logic [BITS-1:0]        rx_buf_d;
  logic                   out_serial_q;
  logic [BITS-1:0]        out_parallel_q;
  logic                   next_word_q;
  logic                   word_valid_q;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdat_sync_q;
  logic                   sclk_prev_q;
  logic                   sdat_prev_q;
  logic                   sclk_now;
  logic                   launch_edge;
  logic                   sample_edge;

  // Map the shift count onto the buffer bit it addresses.
  function automatic logic [IW-1:0] bit_idx(input logic [CW-1:0] ctr);
    if (LOWBIT_FIRST) return IW'(ctr);
    else              return IW'(LAST - ctr);
  endfunction

  // Synchronise clock and data through identical chains so they stay aligned.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      sclk_sync_q <= {SYNC_STAGES{SERIAL_CLK_INACTIVE}};
      sdat_sync_q <= '0;
      sclk_prev_q <= SERIAL_CLK_INACTIVE;
      sdat_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], in_serial_clk};
      sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], in_serial};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      sdat_prev_q <= sdat_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_now    = sclk_sync_q[SYNC_STAGES-1];
  assign launch_edge = (sclk_prev_q == SERIAL_CLK_INACTIVE) && (sclk_now != SERIAL_CLK_INACTIVE);
  assign sample_edge = (sclk_prev_q != SERIAL_CLK_INACTIVE) && (sclk_now == SERIAL_CLK_INACTIVE);

  // Receive buffer with the bit arriving on this sample edge merged in.
  always_comb begin
    rx_buf_d = rx_buf_q;
    rx_buf_d[bit_idx(bit_ctr_q)] = sdat_prev_q;
  end

`ifdef SERIAL_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_ctr_q;
  logic          frame_error_q;
`endif

  // Main FSM: load tx word, wait for launch, shift bits both ways.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q        <= ST_LOAD;
      bit_ctr_q      <= '0;
      tx_buf_q       <= '0;
      rx_buf_q       <= '0;
      out_serial_q   <= SERIAL_DATA_INACTIVE;
      out_parallel_q <= '0;
      next_word_q    <= 1'b0;
      word_valid_q   <= 1'b0;
`ifdef SERIAL_RESP_TIMEOUT_EN
      idle_ctr_q     <= '0;
      frame_error_q  <= 1'b0;
`endif
    end else begin
      next_word_q  <= 1'b0;
      word_valid_q <= 1'b0;
`ifdef SERIAL_RESP_TIMEOUT_EN
      frame_error_q <= 1'b0;
      if ((state_q != ST_SHIFT) || launch_edge || sample_edge) begin
        idle_ctr_q <= '0;
      end else if (sclk_now == SERIAL_CLK_INACTIVE) begin
        idle_ctr_q <= idle_ctr_q + TW'(1);
      end
`endif
      case (state_q)
        ST_LOAD: begin
          tx_buf_q     <= in_parallel;
          next_word_q  <= 1'b1;
          bit_ctr_q    <= '0;
          out_serial_q <= in_parallel[FIRST];
          state_q      <= ST_IDLE;
        end
        ST_IDLE: begin
          out_serial_q <= tx_buf_q[FIRST];
          if (launch_edge) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sample_edge) begin
            rx_buf_q <= rx_buf_d;
            if (bit_ctr_q == LAST) begin
              out_parallel_q <= rx_buf_d;
              word_valid_q   <= 1'b1;
              bit_ctr_q      <= '0;
              state_q        <= ST_LOAD;
            end else begin
              bit_ctr_q <= bit_ctr_q + CW'(1);
            end
          end else if (launch_edge && (bit_ctr_q != '0)) begin
            out_serial_q <= tx_buf_q[bit_idx(bit_ctr_q)];
          end
`ifdef SERIAL_RESP_TIMEOUT_EN
          else if (idle_ctr_q == TLAST) begin
            rx_buf_q      <= '0;
            frame_error_q <= 1'b1;
            bit_ctr_q     <= '0;
            state_q       <= ST_LOAD;
          end
`endif
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign out_serial     = out_serial_q;
  assign out_parallel   = out_parallel_q;
  assign out_next_word  = next_word_q;
  assign out_word_valid = word_valid_q;
  assign out_busy       = (state_q == ST_SHIFT);
`ifdef SERIAL_RESP_TIMEOUT_EN
  assign out_frame_error = frame_error_q;
`else
  assign out_frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_responder.sv
// tb_serial_responder: directed bench for serial_responder. Two instances
// share clock, reset and the serial pins: dut_a shifts LSB first, dut_b MSB
// first. The bench plays the initiator, samples out_serial on each sample
// edge and scoreboards the words received by dut_a.
module tb_serial_responder;

  localparam int HALF = 8;  // serial half-period in in_clk cycles

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       sclk;
  logic       sdi;
  logic [7:0] par_a, par_b;
  logic       ser_a, nw_a, wv_a, busy_a, fe_a;
  logic       ser_b, nw_b, wv_b, busy_b, fe_b;
  logic [7:0] po_a, po_b;

  int checks   = 0;
  int failures = 0;
  int nw_a_cnt = 0;
  int fe_a_cnt = 0;
  int nw_exp   = 0;
  int fe_exp   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] sa, sb;

  // Clock/reset block
  always #10 in_clk = ~in_clk;

  serial_responder #(
    .BITS(8), .LOWBIT_FIRST(1'b1), .SERIAL_CLK_INACTIVE(1'b1),
    .SERIAL_DATA_INACTIVE(1'b1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
  ) dut_a (
    .in_clk(in_clk), .in_rst(in_rst), .in_serial_clk(sclk), .in_serial(sdi),
    .out_serial(ser_a), .in_parallel(par_a), .out_next_word(nw_a),
    .out_parallel(po_a), .out_word_valid(wv_a), .out_busy(busy_a),
    .out_frame_error(fe_a)
  );

  serial_responder #(
    .BITS(8), .LOWBIT_FIRST(1'b0), .SERIAL_CLK_INACTIVE(1'b1),
    .SERIAL_DATA_INACTIVE(1'b1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
  ) dut_b (
    .in_clk(in_clk), .in_rst(in_rst), .in_serial_clk(sclk), .in_serial(sdi),
    .out_serial(ser_b), .in_parallel(par_b), .out_next_word(nw_b),
    .out_parallel(po_b), .out_word_valid(wv_b), .out_busy(busy_b),
    .out_frame_error(fe_b)
  );

  // Output monitor: sampled away from the active edge
  always @(negedge in_clk) begin
    if (!in_rst) begin
      if (wv_a) got_q.push_back(po_a);
      if (nw_a) nw_a_cnt++;
      if (fe_a) fe_a_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver: initiator sends n bits of w; returns out_serial seen at each sample edge
  task automatic send_bits(input logic [7:0] w, input int n, input bit msb,
                           output logic [7:0] bits_a, output logic [7:0] bits_b);
    bits_a = '0;
    bits_b = '0;
    for (int i = 0; i < n; i++) begin
      sdi  = msb ? w[7-i] : w[i];
      sclk = 1'b0;
      repeat (HALF) @(negedge in_clk);
      bits_a[i] = ser_a;
      bits_b[i] = ser_b;
      sclk = 1'b1;
      repeat (HALF) @(negedge in_clk);
    end
  endtask

  // Scoreboard: compare received words against expected queue
  task automatic drain_scoreboard(input string tag);
    check({tag, "_rx_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_rx_word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ser_a"},   ser_a,  1'b1);
    check({tag, "_po_a"},    po_a,   8'h00);
    check({tag, "_nw_a"},    nw_a,   1'b0);
    check({tag, "_wv_a"},    wv_a,   1'b0);
    check({tag, "_busy_a"},  busy_a, 1'b0);
    check({tag, "_fe_a"},    fe_a,   1'b0);
    check({tag, "_po_b"},    po_b,   8'h00);
    check({tag, "_busy_b"},  busy_b, 1'b0);
  endtask

  initial begin
    in_rst = 1'b1;
    sclk   = 1'b1;
    sdi    = 1'b1;
    par_a  = 8'h3C;
    par_b  = 8'h0F;
    repeat (3) @(negedge in_clk);
    check_reset_outputs("reset");

    in_rst = 1'b0;
    repeat (4) @(negedge in_clk);
    nw_exp = 1;
    check("next_word_after_reset", nw_a_cnt, nw_exp);

    // Word 1: receive 0xA5, dut_a transmits 0x3C, dut_b transmits 0x0F MSB first
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 1'b0, sa, sb);
    nw_exp++;
    drain_scoreboard("w1");
    check("w1_tx_a_3c", sa, 8'h3C);
    check("w1_tx_b_0f", sb, 8'hF0);
    check("w1_busy_after", busy_a, 1'b0);
    check("w1_next_word", nw_a_cnt, nw_exp);

    // Word 2: receive 0x81 MSB first on dut_b; next tx word for dut_a set now
    par_a = 8'h55;
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 1'b1, sa, sb);
    nw_exp++;
    drain_scoreboard("w2");
    check("w2_po_b_81", po_b, 8'h81);
    check("w2_tx_a_3c", sa, 8'h3C);
    check("w2_tx_b_0f", sb, 8'hF0);

    // Back-to-back 0x12, 0x34 with in_parallel updated per word
    par_a = 8'h66;
    exp_q.push_back(8'h12);
    send_bits(8'h12, 8, 1'b0, sa, sb);
    check("b2b1_tx_a", sa, 8'h55);
    exp_q.push_back(8'h34);
    send_bits(8'h34, 8, 1'b0, sa, sb);
    check("b2b2_tx_a", sa, 8'h66);
    nw_exp += 2;
    drain_scoreboard("b2b");
    check("b2b_next_word", nw_a_cnt, nw_exp);

`ifdef SERIAL_RESP_TIMEOUT_EN
    // Partial word then idle: timeout abort, then a clean word
    send_bits(8'hFF, 3, 1'b0, sa, sb);
    repeat (100) @(negedge in_clk);
    fe_exp = 1;
    nw_exp++;
    check("to_frame_error", fe_a_cnt, fe_exp);
    check("to_busy_low", busy_a, 1'b0);
    drain_scoreboard("to");
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8, 1'b0, sa, sb);
    nw_exp++;
    drain_scoreboard("to_5a");
`endif

    // Reset after 5 bits of a word
    send_bits(8'hFF, 5, 1'b0, sa, sb);
    check("mid_busy_a", busy_a, 1'b1);
    in_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    par_a = 8'h99;
    repeat (3) @(negedge in_clk);
    in_rst = 1'b0;
    repeat (4) @(negedge in_clk);
    nw_exp++;
    drain_scoreboard("midrst");
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 8, 1'b0, sa, sb);
    nw_exp++;
    drain_scoreboard("c3");
    check("c3_tx_a_99", sa, 8'h99);
    check("final_next_word", nw_a_cnt, nw_exp);
    check("final_frame_error", fe_a_cnt, fe_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
